// File: rtl/display_pkg.sv
// Shared display definitions: digit count, all-off anode code and index-to-anode decode.
// Used by both the scan driver and the segment multiplexer.
package display_pkg;

   localparam int unsigned DISPLAY_DIGITS = 4;
   localparam logic [DISPLAY_DIGITS-1:0] ANODE_OFF = 4'b1111;

   typedef enum logic [1:0] {
      PH_BLANK,
      PH_ON,
      PH_OFF
   } slot_phase_t;

   // Active-low one-hot anode code for a digit index.
   function automatic logic [DISPLAY_DIGITS-1:0] anode_select(input logic [1:0] idx);
      logic [DISPLAY_DIGITS-1:0] sel;
      sel      = ANODE_OFF;
      sel[idx] = 1'b0;
      return sel;
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Modulo-N slot counter with run enable and a terminal-count strobe.
module scan_prescaler #(
   parameter int unsigned N = 100000,
   localparam int unsigned W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         Clock,
   input  logic         Reset_n,
   input  logic         Enable,
   output logic [W-1:0] Count,
   output logic         Terminal
);

   assign Terminal = Enable && (Count == W'(N - 1));

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Count <= '0;
      end else if (Enable) begin
         if (Terminal) begin
            Count <= '0;
         end else begin
            Count <= Count + W'(1);
         end
      end
   end

endmodule

// File: rtl/display_scan_driver.sv
// Four-digit anode scan with dead-time blanking, digit masking and frame strobe.
// Optional per-slot dimming via the Brightness port when SCAN_DIM_EN is defined.
module display_scan_driver
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 500
) (
   input  logic                      Clock,
   input  logic                      Reset_n,
   input  logic                      Enable,
   input  logic [DISPLAY_DIGITS-1:0] DigitMask,
`ifdef SCAN_DIM_EN
   input  logic [3:0]                Brightness,
`endif
   output logic [DISPLAY_DIGITS-1:0] Select,
   output logic [1:0]                DigitIndex,
   output logic                      Blank,
   output logic                      FrameTick
);

   localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CW-1:0]               count;
   logic                        slot_adv;
   logic [1:0]                  index;
   logic [31:0]                 count_ext;
   logic [31:0]                 on_end;
   slot_phase_t                 phase;
   logic [DISPLAY_DIGITS-1:0]   sel_d;

   scan_prescaler #(
      .N(REFRESH_DIV)
   ) u_prescaler (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .Enable  (Enable),
      .Count   (count),
      .Terminal(slot_adv)
   );

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         index <= '0;
      end else if (slot_adv) begin
         index <= index + 2'd1;
      end
   end

`ifdef SCAN_DIM_EN
   localparam int unsigned STEP = (REFRESH_DIV - BLANK_CYCLES) / 16;

   logic [3:0] bright_q;

   // Count 0 always falls in the blank phase, so the new level is in place before any ON cycle.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         bright_q <= 4'd15;
      end else if (count == '0) begin
         bright_q <= Brightness;
      end
   end

   assign on_end = BLANK_CYCLES + STEP * (32'(bright_q) + 32'd1);
`else
   assign on_end = REFRESH_DIV;
`endif

   assign count_ext = 32'(count);

   always_comb begin
      phase = PH_OFF;
      sel_d = ANODE_OFF;
      if (count_ext < BLANK_CYCLES) begin
         phase = PH_BLANK;
      end else if (count_ext < on_end) begin
         phase = PH_ON;
      end
      if (Enable && (phase == PH_ON) && DigitMask[index]) begin
         sel_d = anode_select(index);
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Select     <= ANODE_OFF;
         Blank      <= 1'b1;
         DigitIndex <= '0;
         FrameTick  <= 1'b0;
      end else begin
         Select     <= sel_d;
         Blank      <= (sel_d == ANODE_OFF);
         DigitIndex <= index;
         FrameTick  <= slot_adv && (index == 2'd3);
      end
   end

endmodule

// File: tb/tb_display_scan_driver.sv
// Self-checking bench for display_scan_driver: arithmetic reference model plus directed literals.
module tb_display_scan_driver;

   localparam int unsigned RDIV = 20;
   localparam int unsigned BLK  = 4;

   logic       Clock      = 1'b0;
   logic       Reset_n    = 1'b0;
   logic       Enable     = 1'b0;
   logic [3:0] DigitMask  = 4'hF;
`ifdef SCAN_DIM_EN
   logic [3:0] Brightness = 4'd15;
`endif
   logic [3:0] Select;
   logic [1:0] DigitIndex;
   logic       Blank;
   logic       FrameTick;

   int checks = 0;
   int errors = 0;

   always #5 Clock = ~Clock;

   display_scan_driver #(
      .REFRESH_DIV (RDIV),
      .BLANK_CYCLES(BLK)
   ) dut (
      .Clock     (Clock),
      .Reset_n   (Reset_n),
      .Enable    (Enable),
      .DigitMask (DigitMask),
`ifdef SCAN_DIM_EN
      .Brightness(Brightness),
`endif
      .Select    (Select),
      .DigitIndex(DigitIndex),
      .Blank     (Blank),
      .FrameTick (FrameTick)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: total enabled cycles since reset determine slot position and digit.
   int unsigned ecount   = 0;
   int unsigned m_bright = 15;
   int unsigned m_c, m_d, m_end;
   logic [3:0]  e_sel    = 4'hF;
   logic        e_blank  = 1'b1;
   logic [1:0]  e_idx    = 2'd0;
   logic        e_ft     = 1'b0;

   always @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         ecount   = 0;
         m_bright = 15;
         e_sel    = 4'hF;
         e_blank  = 1'b1;
         e_idx    = 2'd0;
         e_ft     = 1'b0;
      end else begin
         m_c = ecount % RDIV;
         m_d = (ecount / RDIV) % 4;
`ifdef SCAN_DIM_EN
         m_end = BLK + ((RDIV - BLK) / 16) * (m_bright + 1);
`else
         m_end = RDIV;
`endif
         if (Enable && m_c >= BLK && m_c < m_end && DigitMask[m_d] == 1'b1)
            e_sel = ~(4'(4'b0001 << m_d));
         else
            e_sel = 4'hF;
         e_blank = (e_sel == 4'hF);
         e_idx   = 2'(m_d);
         e_ft    = Enable && (ecount % (4 * RDIV) == 4 * RDIV - 1);
`ifdef SCAN_DIM_EN
         if (m_c == 0) m_bright = Brightness;
`endif
         if (Enable) ecount++;
      end
   end

   logic [3:0] last_lit = 4'hF;
   int         off_run  = 0;

   always @(negedge Clock) begin
      check("select", Select, e_sel);
      check("blank", Blank, e_blank);
      check("digit_index", DigitIndex, e_idx);
      check("frame_tick", FrameTick, e_ft);
      check("select_legal", (Select == 4'hF) || ($countones(~Select) == 1), 1);
      if (Select != 4'hF) begin
         if (last_lit != 4'hF && Select != last_lit)
            check("blank_gap", off_run >= BLK, 1);
         last_lit = Select;
         off_run  = 0;
      end else begin
         off_run++;
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge Clock);
         #2;
      end
   endtask

   task automatic restart();
      Reset_n = 1'b0;
      step(2);
      Reset_n = 1'b1;
   endtask

   initial begin
      Enable    = 1'b1;
      DigitMask = 4'hF;
      step(3);
      check("reset_select", Select, 4'hF);
      check("reset_blank", Blank, 1);
      check("reset_index", DigitIndex, 0);
      check("reset_tick", FrameTick, 0);

      // Free run: output after edge e reflects slot count e-1.
      Reset_n = 1'b1;
      step(4);  check("free_d0_blank", Select, 4'b1111);
      step(1);  check("free_d0_on", Select, 4'b1110);
      step(19); check("free_d1_blank", Select, 4'b1111);
      step(1);  check("free_d1_on", Select, 4'b1101);
      step(40); check("free_d3_on", Select, 4'b0111);
      step(15); check("free_tick", FrameTick, 1);
      check("free_tick_idx", DigitIndex, 3);
      step(1);  check("free_tick_end", FrameTick, 0);
      check("free_wrap_idx", DigitIndex, 0);

      // Mask: digits 1 and 3 dark.
      DigitMask = 4'b0101;
      restart();
      step(30); check("mask_d1_dark", Select, 4'b1111);
      check("mask_d1_idx", DigitIndex, 1);
      step(20); check("mask_d2_lit", Select, 4'b1011);

      // Enable gap at count 10 of digit 2.
      DigitMask = 4'hF;
      restart();
      step(50);
      Enable = 1'b0;
      step(1);  check("gap_off", Select, 4'b1111);
      check("gap_idx", DigitIndex, 2);
      step(6);  check("gap_hold", Select, 4'b1111);
      Enable = 1'b1;
      step(1);  check("gap_resume", Select, 4'b1011);
      step(9);  check("gap_last_on", Select, 4'b1011);
      step(1);  check("gap_next_blank", Select, 4'b1111);
      check("gap_next_idx", DigitIndex, 3);

      // Async reset mid-ON of digit 3.
      restart();
      step(69); check("areset_before", Select, 4'b0111);
      #1 Reset_n = 1'b0;
      #1;
      check("areset_select", Select, 4'b1111);
      check("areset_blank", Blank, 1);
      check("areset_idx", DigitIndex, 0);
      step(2);
      Reset_n = 1'b1;
      step(4);  check("areset_restart_blank", Select, 4'b1111);
      step(1);  check("areset_restart_on", Select, 4'b1110);

`ifdef SCAN_DIM_EN
      Brightness = 4'd3;
      restart();
      step(8);  check("dim_on", Select, 4'b1110);
      step(1);  check("dim_off", Select, 4'b1111);
      step(17);
      Brightness = 4'd15;
      step(1);  check("dim_d1_on", Select, 4'b1101);
      step(2);  check("dim_d1_still_3", Select, 4'b1111);
      step(20); check("dim_d2_full", Select, 4'b1011);
      step(11); check("dim_d2_end", Select, 4'b1011);
`endif

      restart();
      for (int i = 0; i < 1000; i++) begin
         Enable    = ($urandom_range(0, 3) != 0);
         DigitMask = 4'($urandom_range(0, 15));
`ifdef SCAN_DIM_EN
         Brightness = 4'($urandom_range(0, 15));
`endif
         if ($urandom_range(0, 99) == 0) begin
            Reset_n = 1'b0;
            step(1);
            Reset_n = 1'b1;
         end
         step($urandom_range(1, 8));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Generates the time-multiplexed digit-select sequence for the board's 4-digit common-anode 7-segment display. It drives the active-low one-hot `Select` consumed by the display multiplexer and the anode transistors. It adds dead-time blanking between digits to suppress ghosting and per-digit masking. A digit index and a frame pulse are provided for upstream digit-data producers.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles per digit slot; 1 kHz per digit at 100 MHz. Must be ≥ `BLANK_CYCLES` + 16.
- `BLANK_CYCLES`, default 500: dead-time cycles at the start of each slot with all anodes off. Must be ≥ 1.
- `Clock`  in  1: single system clock, rising edge.
- `Reset_n`  in  1: reset; asynchronous, active-low.
- `Enable`  in  1: scan run enable.
- `DigitMask`  in  4: bit i = 1 allows digit i to light.
- `Brightness`  in  4: duty level, 0 = dimmest, 15 = full. Present only with `SCAN_DIM_EN`.
- `Select`  out  4: active-low one-hot anode select; 4'b1111 = all off.
- `DigitIndex`  out  2: index of the current slot, 0–3.
- `Blank`  out  1: 1 while `Select` = 4'b1111 for any reason.
- `FrameTick`  out  1: one-cycle pulse when the index wraps 3→0.

## Operation
- State:
  - slot counter `Count`, 0..`REFRESH_DIV`-1
  - digit index `Index`, 0..3
  - registered outputs
- Each enabled cycle `Count` increments. At `REFRESH_DIV`-1 it wraps to 0 and `Index` increments modulo 4.
- Slot phases:
  - BLANK: `Count` < `BLANK_CYCLES`.
  - ON: `Count` ≥ `BLANK_CYCLES` and within the on-window.
  - OFF: the remainder, reachable only with dimming.
- `Select` during ON: bit `Index` = 0 and all other bits = 1. During this time, also `DigitMask[Index]` = 1. Otherwise `Select` = 4'b1111.
- Masked digits still occupy their slot time; the index is never skipped. `DigitMask` = 0 gives a permanently dark display with normal `FrameTick` cadence.
- `DigitMask` is sampled every cycle. A change affects `Select` on the next output update.
- `Enable` = 0:
  - `Count` and `Index` hold.
  - `Select` = 4'b1111, `Blank` = 1, `FrameTick` = 0.
- `Enable` returning to 1 resumes from the held `Count`/`Index`. No extra blanking is inserted.
- `FrameTick` asserts for exactly one cycle per 4·`REFRESH_DIV` enabled cycles, coincident with `Index` wrapping 3→0.
- `Blank` is 1 exactly when `Select` = 4'b1111.

## Timing
- All outputs are registered. Outputs in cycle t+1 reflect `Count`, `Index`, `Enable`, `DigitMask` and the latched brightness at cycle t. Latency is 1 cycle.
- Reset values, applied immediately and asynchronously:
  - `Count` = 0, `Index` = 0
  - `Select` = 4'b1111
  - `DigitIndex` = 0
  - `Blank` = 1
  - `FrameTick` = 0
- After release, the first slot is digit 0 starting with its BLANK phase.
- Reset asserted mid-slot forces `Select` to all-off in the same cycle. No partial slot resumes.
- Between any two distinct lit digits, `Select` = 4'b1111 for ≥ `BLANK_CYCLES` cycles. Two anodes are never low simultaneously, including across reset and enable edges.

## Configuration
- Macro `SCAN_DIM_EN`.
- Defined:
  - `Brightness` port exists.
  - `Brightness` is latched into an internal register when `Count` = 0, and holds for the whole slot.
  - Step size STEP = (`REFRESH_DIV` − `BLANK_CYCLES`) / 16, truncating.
  - The on-window is `BLANK_CYCLES` ≤ `Count` < `BLANK_CYCLES` + STEP·(B+1).
  - Later cycles in the slot are OFF.
  - With B = 15, up to 15 truncation-remainder cycles stay dark.
  - The latched value resets to 15.
- Undefined: no `Brightness` port and no latch. The on-window is the entire post-blank slot.

## Structure
- Shared package `display_pkg`:
  - `DISPLAY_DIGITS` = 4
  - `ANODE_OFF` = 4'b1111
  - function returning the active-low one-hot for a 2-bit index
  - This package is also used by the multiplexer side.
- Sub-module `scan_prescaler`:
  - Parameterised modulo-N counter with enable, asynchronous active-low reset, and terminal-count strobe.
  - Provides `Count` and the slot-advance strobe.

## Test plan
Use `REFRESH_DIV` = 20 and `BLANK_CYCLES` = 4 throughout.

- **Free run.** Release reset with `Enable` = 1 and `DigitMask` = 4'b1111.
  - `Select` is 1111 for 4 cycles, then 1110 for 16 cycles.
  - Next slot: 1111 for 4 cycles, then 1101 for 16 cycles, continuing through 1011 and 0111.
  - `FrameTick` pulses every 80 cycles, when `DigitIndex` goes 3→0.
- **Mask.** Set `DigitMask` = 4'b0101.
  - Slots 1 and 3 keep `Select` = 1111 and `Blank` = 1 for all 20 cycles.
  - `DigitIndex` still steps 0,1,2,3.
- **Enable gap.** Drop `Enable` at `Count` = 10 of digit 2 for 7 cycles.
  - `Select` = 1111 starting the next cycle and `DigitIndex` holds at 2.
  - On re-enable, 1011 resumes for the remaining 10 ON cycles.
- **Async reset.** Assert `Reset_n` = 0 mid-ON of digit 3.
  - `Select` = 1111 without a clock edge.
  - After release, the sequence restarts at digit 0 BLANK.
- **Dimming** (`SCAN_DIM_EN`, STEP = 1). Set `Brightness` = 3.
  - Each slot is 1111 for 4 cycles, the digit code for 4 cycles, then 1111 for 12 cycles.
  - Changing to 15 at `Count` = 6 applies only from the next slot, which then gives 16 ON cycles.
- **Overlap check.** Run 1000 random `Enable`/`DigitMask` changes.
  - An assertion checks that `Select` is never anything other than all-off or one-hot-low.
  - An assertion checks that a change between two different lit digits is always separated by ≥ 4 cycles of 1111.
